// File: rtl/wb_regfile_bypass_pkg.sv
// Shared sizing constants and types for the writeback register file slice.
package wb_regfile_bypass_pkg;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 3;

   typedef logic [DATA_W-1:0] dataWord_t;
   typedef logic [ADDR_W-1:0] regIdx_t;
endpackage

// File: rtl/wb_regfile_bypass_rf_core.sv
// Architectural register storage: async clear, one write port, two raw read ports.
module rf_core
   import wb_regfile_bypass_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      wrEn,
   input  regIdx_t   wrAddr,
   input  dataWord_t wrData,
   input  regIdx_t   rdAddr1,
   input  regIdx_t   rdAddr2,
   output dataWord_t rdData1,
   output dataWord_t rdData2
);

   dataWord_t regs [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[wrAddr] <= wrData;
      end
   end

   assign rdData1 = regs[rdAddr1];
   assign rdData2 = regs[rdAddr2];

endmodule

// File: rtl/wb_regfile_bypass.sv
// Writeback stage consumer: selects the writeback value, commits it to the
// register file and forwards it to same-cycle decode reads.
module wb_regfile_bypass
   import wb_regfile_bypass_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  dataWord_t wb_mem_data,
   input  dataWord_t wb_alu_data,
   input  logic      wb_val2reg,
   input  logic      wb_wr_en,
   input  regIdx_t   wb_wr_reg,
   input  regIdx_t   rd_reg1,
   input  regIdx_t   rd_reg2,
   output dataWord_t rd_data1,
   output dataWord_t rd_data2,
   output dataWord_t wb_data,
   output logic      err
);

   dataWord_t wbSel;
   dataWord_t rawData1;
   dataWord_t rawData2;
   logic      wrIdxBad;
   logic      coreWrEn;
   logic      bypass1;
   logic      bypass2;

   assign wbSel    = wb_val2reg ? wb_mem_data : wb_alu_data;

   // Only reachable when ADDR_W is wider than NUM_REGS needs; such writes are dropped.
   assign wrIdxBad = wb_wr_en && (32'(wb_wr_reg) >= NUM_REGS);
   assign coreWrEn = wb_wr_en && !wrIdxBad;

   rf_core uCore (
      .clk     (clk),
      .rst     (rst),
      .wrEn    (coreWrEn),
      .wrAddr  (wb_wr_reg),
      .wrData  (wbSel),
      .rdAddr1 (rd_reg1),
      .rdAddr2 (rd_reg2),
      .rdData1 (rawData1),
      .rdData2 (rawData2)
   );

   assign bypass1 = coreWrEn && (wb_wr_reg == rd_reg1);
   assign bypass2 = coreWrEn && (wb_wr_reg == rd_reg2);

   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      wb_data  = '0;
      if (!rst) begin
         rd_data1 = bypass1 ? wbSel : rawData1;
         rd_data2 = bypass2 ? wbSel : rawData2;
         wb_data  = wbSel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (wrIdxBad) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile_bypass.sv
// Self-checking bench for wb_regfile_bypass against an array-based register model.
module tb_wb_regfile_bypass;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] wb_mem_data;
   logic [15:0] wb_alu_data;
   logic        wb_val2reg;
   logic        wb_wr_en;
   logic [2:0]  wb_wr_reg;
   logic [2:0]  rd_reg1;
   logic [2:0]  rd_reg2;
   logic [15:0] rd_data1;
   logic [15:0] rd_data2;
   logic [15:0] wb_data;
   logic        err;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] mdl [8];

   wb_regfile_bypass dut (
      .clk         (clk),
      .rst         (rst),
      .wb_mem_data (wb_mem_data),
      .wb_alu_data (wb_alu_data),
      .wb_val2reg  (wb_val2reg),
      .wb_wr_en    (wb_wr_en),
      .wb_wr_reg   (wb_wr_reg),
      .rd_reg1     (rd_reg1),
      .rd_reg2     (rd_reg2),
      .rd_data1    (rd_data1),
      .rd_data2    (rd_data2),
      .wb_data     (wb_data),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] selModel();
      return wb_val2reg ? wb_mem_data : wb_alu_data;
   endfunction

   function automatic logic [15:0] expRd(input logic [2:0] idx);
      if (rst) return 16'h0000;
      if (wb_wr_en && wb_wr_reg == idx) return selModel();
      return mdl[idx];
   endfunction

   function automatic logic [15:0] expWb();
      return rst ? 16'h0000 : selModel();
   endfunction

   task automatic setRst(input logic v);
      rst = v;
      if (v) begin
         for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      end
   endtask

   // Advance one rising edge, commit to the model, then land 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst && wb_wr_en) mdl[wb_wr_reg] = selModel();
      #1;
   endtask

   task automatic drive(input logic en, input logic [2:0] wr, input logic sel,
                        input logic [15:0] mem, input logic [15:0] alu);
      wb_wr_en    = en;
      wb_wr_reg   = wr;
      wb_val2reg  = sel;
      wb_mem_data = mem;
      wb_alu_data = alu;
   endtask

   task automatic test_reset();
      setRst(1'b1);
      drive(1'b1, 3'd1, 1'b0, 16'h7777, 16'h6666);
      rd_reg1 = 3'd1;
      rd_reg2 = 3'd1;
      tick();
      tick();
      #1;
      checks++;
      if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000 || wb_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_gating: got rd1=%h rd2=%h wb=%h required 0000", rd_data1, rd_data2, wb_data);
      end
      wb_wr_en = 1'b0;
      setRst(1'b0);
      for (int i = 0; i < 8; i++) begin
         rd_reg1 = 3'(i);
         rd_reg2 = 3'(7 - i);
         #1;
         checks++;
         if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read R%0d: got rd1=%h rd2=%h required 0000", i, rd_data1, rd_data2);
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %b required 0", err);
      end
   endtask

   task automatic test_alu_write();
      drive(1'b1, 3'd3, 1'b0, 16'h9999, 16'h1234);
      tick();
      wb_wr_en = 1'b0;
      rd_reg1  = 3'd3;
      rd_reg2  = 3'd2;
      #1;
      checks++;
      if (rd_data1 !== 16'h1234) begin
         errors++;
         $display("FAIL alu_write R3: got %h required 1234", rd_data1);
      end
      checks++;
      if (rd_data2 !== 16'h0000) begin
         errors++;
         $display("FAIL alu_write R2: got %h required 0000", rd_data2);
      end
   endtask

   task automatic test_mem_write();
      drive(1'b1, 3'd7, 1'b1, 16'hBEEF, 16'h5555);
      rd_reg1 = 3'd0;
      #1;
      checks++;
      if (wb_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL mem_select: got %h required beef", wb_data);
      end
      tick();
      wb_wr_en = 1'b0;
      rd_reg1  = 3'd7;
      #1;
      checks++;
      if (rd_data1 !== 16'hBEEF) begin
         errors++;
         $display("FAIL mem_write R7: got %h required beef", rd_data1);
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 3'd5, 1'b0, 16'h0000, 16'h0001);
      tick();
      drive(1'b1, 3'd5, 1'b0, 16'h3C3C, 16'hA5A5);
      rd_reg1 = 3'd5;
      rd_reg2 = 3'd5;
      #1;
      checks++;
      if (rd_data1 !== 16'hA5A5 || rd_data2 !== 16'hA5A5) begin
         errors++;
         $display("FAIL bypass_both: got rd1=%h rd2=%h required a5a5", rd_data1, rd_data2);
      end
      wb_wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data1 !== 16'h0001) begin
         errors++;
         $display("FAIL bypass_off: got %h required 0001", rd_data1);
      end
   endtask

   task automatic test_back_to_back();
      rd_reg1 = 3'd2;
      drive(1'b1, 3'd2, 1'b0, 16'h0000, 16'h1111);
      #1;
      checks++;
      if (rd_data1 !== 16'h1111) begin
         errors++;
         $display("FAIL b2b_first: got %h required 1111", rd_data1);
      end
      tick();
      wb_alu_data = 16'h2222;
      #1;
      checks++;
      if (rd_data1 !== 16'h2222) begin
         errors++;
         $display("FAIL b2b_second: got %h required 2222", rd_data1);
      end
      tick();
      wb_wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data1 !== 16'h2222) begin
         errors++;
         $display("FAIL b2b_storage: got %h required 2222", rd_data1);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 3'd4, 1'b0, 16'h0000, 16'hFFFF);
      tick();
      drive(1'b1, 3'd4, 1'b0, 16'h0000, 16'h0F0F);
      rd_reg1 = 3'd4;
      rd_reg2 = 3'd3;
      #1;
      setRst(1'b1);
      #1;
      checks++;
      if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000 || wb_data !== 16'h0000) begin
         errors++;
         $display("FAIL async_clear: got rd1=%h rd2=%h wb=%h required 0000", rd_data1, rd_data2, wb_data);
      end
      tick();
      wb_wr_en = 1'b0;
      setRst(1'b0);
      #1;
      checks++;
      if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin
         errors++;
         $display("FAIL async_discard: got R4=%h R3=%h required 0000", rd_data1, rd_data2);
      end
      wb_wr_en = 1'b1;
      tick();
      wb_wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data1 !== 16'h0F0F) begin
         errors++;
         $display("FAIL async_rewrite: got %h required 0f0f", rd_data1);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom));
         rd_reg1 = 3'($urandom_range(0, 7));
         rd_reg2 = 3'($urandom_range(0, 7));
         if (rst) setRst(1'b0);
         else if ($urandom_range(0, 24) == 0) setRst(1'b1);
         #1;
         checks++;
         if (rd_data1 !== expRd(rd_reg1) || rd_data2 !== expRd(rd_reg2) || wb_data !== expWb()) begin
            errors++;
            $display("FAIL random[%0d]: got rd1=%h rd2=%h wb=%h required rd1=%h rd2=%h wb=%h",
                     n, rd_data1, rd_data2, wb_data, expRd(rd_reg1), expRd(rd_reg2), expWb());
         end
         tick();
      end
      setRst(1'b0);
      wb_wr_en = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_final: got %b required 0", err);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      rst = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
      rd_reg1 = 3'd0;
      rd_reg2 = 3'd0;
      test_reset();
      test_alu_write();
      test_mem_write();
      test_bypass();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
